// File: rtl/result_tx_sequencer.sv
// rtl/result_tx_sequencer.sv - result matrix to UART byte stream sequencer
//
// Purpose:
//   Responds to the control unit's tx_start/tx_busy handshake. On a start
//   request the result matrix is snapshotted, then sent row-major as bytes
//   (optional header byte first, each element MSB byte first), one byte per
//   uart_send/uart_busy handshake with the UART TX core.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   tx_start    in   start request (only sampled while idle)
//   result_mat  in   flattened matrix, element k at [k*DATA_W +: DATA_W]
//   uart_busy   in   UART TX core busy
//   tx_busy     out  transfer in progress
//   uart_data   out  byte to transmit
//   uart_send   out  one-cycle send strobe
//   tx_done     out  one-cycle pulse after the last byte completes
//   tx_err      out  one-cycle pulse when the UART never acknowledged a send
module result_tx_sequencer #(
  parameter int         N           = 2,
  parameter int         DATA_W      = 16,
  parameter int         SEND_HEADER = 1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_start,
  input  logic [N*N*DATA_W-1:0]   result_mat,
  input  logic                    uart_busy,
  output logic                    tx_busy,
  output logic [7:0]              uart_data,
  output logic                    uart_send,
  output logic                    tx_done,
  output logic                    tx_err
);

  localparam int NEL = N * N;
  localparam int BPE = DATA_W / 8;
  localparam int EW  = (NEL > 1) ? $clog2(NEL) : 1;
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [EW-1:0] LAST_ELEM = EW'(NEL - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPE - 1);
  // Counter runs ACK_TIMEOUT-1 down to 0, giving ACK_TIMEOUT waiting cycles.
  localparam logic [TW-1:0] TO_LOAD   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [N*N*DATA_W-1:0]   snap;
  logic                    snap_ld;
  logic [EW-1:0]           elem_cnt, elem_n;
  logic [BW-1:0]           byte_cnt, byte_n;
  logic                    hdr_pend, hdr_n;
  logic [TW-1:0]           to_cnt, to_n;
  logic                    busy_n, send_n, done_n, err_n;
  logic [7:0]              data_n;
  logic [DATA_W-1:0]       cur_elem;
  logic [7:0]              cur_byte;
  logic                    is_last;

  // Byte selection from the snapshot: element by elem_cnt, byte MSB first.
  always_comb begin
    cur_elem = '0;
    for (int k = 0; k < NEL; k++) begin
      if (elem_cnt == EW'(k)) cur_elem = snap[k*DATA_W +: DATA_W];
    end
    cur_byte = '0;
    for (int b = 0; b < BPE; b++) begin
      if (byte_cnt == BW'(b)) cur_byte = cur_elem[(BPE-1-b)*8 +: 8];
    end
  end

  assign is_last = !hdr_pend && (elem_cnt == LAST_ELEM) && (byte_cnt == LAST_BYTE);

  always_comb begin
    state_n = state;
    snap_ld = 1'b0;
    elem_n  = elem_cnt;
    byte_n  = byte_cnt;
    hdr_n   = hdr_pend;
    to_n    = to_cnt;
    busy_n  = tx_busy;
    data_n  = uart_data;
    send_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          snap_ld = 1'b1;
          elem_n  = '0;
          byte_n  = '0;
          hdr_n   = (SEND_HEADER != 0);
          busy_n  = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        data_n  = hdr_pend ? HEADER_BYTE : cur_byte;
        state_n = SEND;
      end
      SEND: begin
        // A UART still busy from elsewhere stalls here without arming the timeout.
        if (!uart_busy) begin
          send_n  = 1'b1;
          to_n    = TO_LOAD;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart_busy) begin
          state_n = WAIT_IDLE;
        end else if (to_cnt == '0) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          to_n = to_cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!uart_busy) begin
          if (is_last) begin
            // tx_done is visible while in DONE, so a start in that cycle is ignored.
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            if (hdr_pend) begin
              hdr_n = 1'b0;
            end else if (byte_cnt == LAST_BYTE) begin
              byte_n = '0;
              elem_n = elem_cnt + 1'b1;
            end else begin
              byte_n = byte_cnt + 1'b1;
            end
            state_n = LOAD;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      elem_cnt  <= '0;
      byte_cnt  <= '0;
      hdr_pend  <= 1'b0;
      to_cnt    <= '0;
      tx_busy   <= 1'b0;
      uart_data <= 8'h00;
      uart_send <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state     <= state_n;
      if (snap_ld) snap <= result_mat;
      elem_cnt  <= elem_n;
      byte_cnt  <= byte_n;
      hdr_pend  <= hdr_n;
      to_cnt    <= to_n;
      tx_busy   <= busy_n;
      uart_data <= data_n;
      uart_send <= send_n;
      tx_done   <= done_n;
      tx_err    <= err_n;
    end
  end

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Serializes the finished result matrix into bytes for the byte-level UART transmitter.
- Sits between the control unit and the UART TX core.
- Is the responder for the control unit's `tx_start` / `tx_busy` handshake.
- On a start request it snapshots the result matrix, then streams it out row-major, one byte per UART handshake, holding `tx_busy` high for the whole transfer.

Parameters:
- N, 2, matrix dimension; the matrix has N*N elements.
- DATA_W, 16, element width in bits; must be a multiple of 8.
- SEND_HEADER, 1, 1 = send HEADER_BYTE before the elements; 0 = no header.
- HEADER_BYTE, 8'hA5, framing byte.
- ACK_TIMEOUT, 15, maximum cycles to wait for `uart_busy` to rise after a `uart_send`.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tx_start  input  1  start request from the control unit
- result_mat  input  N*N*DATA_W  flattened result matrix; element k = row*N+col sits at [k*DATA_W +: DATA_W]
- uart_busy  input  1  UART TX core busy
- tx_busy  output  1  transfer in progress, to the control unit
- uart_data  output  8  byte to transmit
- uart_send  output  1  one-cycle send strobe to the UART TX core
- tx_done  output  1  one-cycle pulse when the last byte completes
- tx_err  output  1  one-cycle pulse on ack timeout

Behaviour:
- All outputs are registered.
- Reset value of every output is 0: `tx_busy`, `uart_data`, `uart_send`, `tx_done`, `tx_err`. The state machine returns to IDLE and all counters clear.
- Reset mid-transfer aborts immediately; no further `uart_send` is issued.
- States: IDLE, LOAD, SEND, WAIT_ACK, WAIT_IDLE, DONE.
- IDLE:
  - `tx_start` is treated as a pulse; only its level while in IDLE matters.
  - The control unit may drop it after one cycle because `tx_busy` is registered.
  - When `tx_start` = 1 in IDLE: latch `result_mat` into an internal snapshot, clear the element and byte counters, set `tx_busy` = 1 on the next edge, go to LOAD.
  - Later `result_mat` changes do not affect the transfer.
- LOAD:
  - Select the next byte into `uart_data`.
  - Byte order is the header first (if SEND_HEADER), then element 0..N*N-1.
  - Each element is sent MSB byte first: DATA_W/8 bytes.
  - Go to SEND.
- SEND:
  - When `uart_busy` = 0, assert `uart_send` for exactly one cycle, load the timeout counter, go to WAIT_ACK.
  - Otherwise hold.
  - `uart_data` is stable from LOAD until WAIT_IDLE exits.
- WAIT_ACK:
  - `uart_busy` = 1: go to WAIT_IDLE.
  - Otherwise decrement the timeout counter. After ACK_TIMEOUT cycles without ack: pulse `tx_err`, clear `tx_busy`, go to IDLE with the transfer abandoned.
- WAIT_IDLE:
  - Wait for `uart_busy` = 0.
  - If bytes remain, advance the byte counter; on byte wrap at DATA_W/8 - 1, reset it and advance the element counter. Go to LOAD.
  - If this was the last byte, go to DONE.
- DONE: pulse `tx_done` for one cycle, clear `tx_busy` on the same edge, go to IDLE.
  - Minimum gap between the last byte's `uart_busy` fall and `tx_busy` = 0 is 2 cycles.
- Total bytes = SEND_HEADER + N*N*DATA_W/8; defaults give 9.
- `tx_start` while `tx_busy` = 1 is ignored; there is no queuing or restart.
- `tx_start` in the same cycle `tx_done` pulses is also ignored (the FSM is in DONE). A new start is accepted from the next IDLE cycle.
- `uart_busy` already high when entering SEND: stall in SEND; the timeout is not armed.

Test Plan:
- Basic transfer: N=2, DATA_W=16, SEND_HEADER=1, `result_mat` elements {0x1234, 0xABCD, 0x0001, 0xFF00}, one-cycle `tx_start`, UART model busy for 10 cycles per byte.
  - Required: 9 `uart_send` strobes with bytes A5,12,34,AB,CD,00,01,FF,00.
  - `tx_busy` high from the cycle after start until `tx_done`; exactly one `tx_done` pulse.
- Snapshot: change `result_mat` to all 0xFFFF two cycles after start.
  - Required: the byte stream is unchanged from the basic case.
- Ignored starts:
  - Pulse `tx_start` repeatedly during a transfer: still exactly 9 bytes and one `tx_done`.
  - Start immediately after `tx_done`: a second full 9-byte transfer.
- Slow and pre-busy UART: hold `uart_busy` = 1 for 40 cycles before the first byte.
  - Required: no `uart_send` until it drops, no `tx_err`, correct stream.
- Ack timeout: UART model never raises `uart_busy`.
  - Required: single `uart_send` of A5.
  - `tx_err` pulses 15 cycles later; `tx_busy` falls; no `tx_done`.
- Reset mid-operation: assert `rst` after the third byte.
  - Required: all outputs 0 immediately, no further strobes.
  - A new `tx_start` after release yields a full 9-byte stream from A5.
